// File: rtl/bf_sequencer_if.sv
// Host-side bundle for bf_sequencer: run control, weight-row load handshake,
// relaxation pacing and status. The sequencer drives the slave modport.
interface bf_sequencer_if #(
  parameter int NODES  = 32,
  parameter int ITER_W = 11
);
  localparam int AW = (NODES > 1) ? $clog2(NODES) : 1;

  logic              start;
  logic              abort;
  logic              load_valid;
  logic              relax_update;
  logic              load_ready;
  logic              row_wr;
  logic [AW-1:0]     row_addr;
  logic              read_enable_global;
  logic              iteration_done;
  logic [ITER_W-1:0] iter_count;
  logic              busy;
  logic              done;
  logic              converged;
  logic              neg_cycle;
  logic [2:0]        state;

  modport slave (
    input  start, abort, load_valid, relax_update,
    output load_ready, row_wr, row_addr, read_enable_global, iteration_done,
           iter_count, busy, done, converged, neg_cycle, state
  );

  modport master (
    output start, abort, load_valid, relax_update,
    input  load_ready, row_wr, row_addr, read_enable_global, iteration_done,
           iter_count, busy, done, converged, neg_cycle, state
  );
endinterface

// File: rtl/bf_sequencer.sv
// Bellman-Ford run controller: loads the weight matrix, paces relaxation
// iterations and reports status. Define BF_EARLY_EXIT_EN to stop on convergence.
module bf_sequencer #(
  parameter int NODES        = 32,
  parameter int ITER_CYCLES  = 6,
  parameter int MAX_ITER     = 20,
  parameter int ITER_W       = 11,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_global_n,
  bf_sequencer_if.slave    bus
);

  localparam int AW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int CW = $clog2(ITER_CYCLES);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     row_addr_q, row_addr_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              upd_q, upd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              neg_q, neg_d;

  logic              u;
  logic [ITER_W-1:0] iter_inc;

  // NOTE: every next-state variable takes its held value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    row_addr_d = row_addr_q;
    cyc_d      = cyc_q;
    drain_d    = drain_q;
    upd_d      = upd_q;
    iter_d     = iter_q;
    conv_d     = conv_q;
    neg_d      = neg_q;
    u          = upd_q | bus.relax_update;
    iter_inc   = iter_q + ITER_W'(1);

    if (bus.abort) begin
      // Abort only cancels an active run; in IDLE it merely blocks start.
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        conv_d  = 1'b0;
        neg_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_LOAD;
            row_addr_d = '0;
            iter_d     = '0;
            conv_d     = 1'b0;
            neg_d      = 1'b0;
            cyc_d      = '0;
            upd_d      = 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.load_valid) begin
            if (row_addr_q == AW'(NODES - 1)) begin
              row_addr_d = '0;
              state_d    = S_RUN;
            end else begin
              row_addr_d = row_addr_q + AW'(1);
            end
          end
        end
        S_RUN: begin
          if (cyc_q == CW'(ITER_CYCLES - 1)) begin
            cyc_d  = '0;
            upd_d  = 1'b0;
            iter_d = iter_inc;
            if (iter_inc == ITER_W'(MAX_ITER)) begin
              neg_d   = u;
              conv_d  = ~u;
              drain_d = '0;
              state_d = S_DRAIN;
            end
`ifdef BF_EARLY_EXIT_EN
            else if (!u) begin
              conv_d  = 1'b1;
              neg_d   = 1'b0;
              drain_d = '0;
              state_d = S_DRAIN;
            end
`endif
          end else begin
            cyc_d = cyc_q + CW'(1);
            upd_d = u;
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state_q    <= S_IDLE;
      row_addr_q <= '0;
      cyc_q      <= '0;
      drain_q    <= '0;
      upd_q      <= 1'b0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_addr_q <= row_addr_d;
      cyc_q      <= cyc_d;
      drain_q    <= drain_d;
      upd_q      <= upd_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      neg_q      <= neg_d;
    end
  end

  // Only row_wr sees an input directly; everything else decodes registers.
  assign bus.load_ready         = (state_q == S_LOAD);
  assign bus.row_wr             = bus.load_valid & (state_q == S_LOAD);
  assign bus.row_addr           = row_addr_q;
  assign bus.read_enable_global = (state_q == S_RUN) && (cyc_q == '0) && (iter_q == '0);
  assign bus.iteration_done     = (state_q == S_RUN) && (cyc_q == CW'(ITER_CYCLES - 1));
  assign bus.iter_count         = iter_q;
  assign bus.busy               = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done               = (state_q == S_DONE);
  assign bus.converged          = conv_q;
  assign bus.neg_cycle          = neg_q;
  assign bus.state              = state_q;

endmodule

// File: tb/tb_bf_sequencer.sv
// Self-checking bench for bf_sequencer: timed output events are predicted into
// a scoreboard queue at stimulus time and matched as the DUT produces them.
module tb_bf_sequencer;
  localparam int NODES        = 4;
  localparam int ITER_CYCLES  = 6;
  localparam int MAX_ITER     = 4;
  localparam int ITER_W       = 11;
  localparam int DRAIN_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_global_n = 1'b0;
  always #5 clk = ~clk;

  bf_sequencer_if #(.NODES(NODES), .ITER_W(ITER_W)) bus ();

  bf_sequencer #(
    .NODES(NODES), .ITER_CYCLES(ITER_CYCLES), .MAX_ITER(MAX_ITER),
    .ITER_W(ITER_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk),
    .rst_global_n(rst_global_n),
    .bus(bus)
  );

  typedef enum int {EV_WR, EV_RE, EV_ITD, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       val;
  } ev_t;

  ev_t sb_q[$];
  ev_t obs_q[$];
  ev_t exp_ev;
  int  checks = 0;
  int  errors = 0;
  int  cyc_n = 0;
  int  t0 = 0;
  int  relax_mode = 0;
  int  valid_mode = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard: every strobe the DUT raises must match the next prediction.
  always @(negedge clk) begin
    if (rst_global_n) begin
      obs_q.delete();
      if (bus.row_wr)             obs_q.push_back('{EV_WR, cyc_n, int'(bus.row_addr)});
      if (bus.read_enable_global) obs_q.push_back('{EV_RE, cyc_n, 0});
      if (bus.iteration_done)     obs_q.push_back('{EV_ITD, cyc_n, int'(bus.iter_count)});
      if (bus.done)
        obs_q.push_back('{EV_DONE, cyc_n, (int'(bus.busy) << 18) | (int'(bus.converged) << 17) |
                                          (int'(bus.neg_cycle) << 16) | int'(bus.iter_count)});
      foreach (obs_q[i]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %s at cycle %0d val 0x%0h, expected no event",
                   obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].val);
        end else begin
          exp_ev = sb_q.pop_front();
          if (obs_q[i].kind !== exp_ev.kind || obs_q[i].cyc !== exp_ev.cyc ||
              obs_q[i].val !== exp_ev.val) begin
            errors++;
            $display("FAIL sb_event: got %s@%0d val 0x%0h, expected %s@%0d val 0x%0h",
                     obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].val,
                     exp_ev.kind.name(), exp_ev.cyc, exp_ev.val);
          end
        end
      end
    end
  end

  function automatic int done_exp(int conv, int neg, int iter);
    return (conv << 17) | (neg << 16) | iter;
  endfunction

  task automatic push_ev(ev_kind_e kind, int off, int val);
    sb_q.push_back('{kind, t0 + off, val});
  endtask

  // Advance one cycle and drive the per-cycle inputs for the new cycle.
  task automatic tick();
    int off;
    @(posedge clk);
    #1;
    off = cyc_n - t0;
    case (relax_mode)
      1:       bus.relax_update = 1'b1;
      2:       bus.relax_update = (off >= 5 && off <= 10);
      3:       bus.relax_update = (off == 28);
      default: bus.relax_update = 1'b0;
    endcase
    case (valid_mode)
      1:       bus.load_valid = 1'b1;
      2:       bus.load_valid = (off >= 1) && (off % 2 == 1);
      default: bus.load_valid = 1'b0;
    endcase
  endtask

  task automatic run_to(int off);
    while (cyc_n - t0 < off) tick();
  endtask

  task automatic begin_run(int rmode, int vmode);
    t0 = cyc_n;
    relax_mode = rmode;
    valid_mode = vmode;
    bus.start = 1'b1;
  endtask

  task automatic launch();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic push_std_events(int iters);
    for (int i = 0; i < NODES; i++) push_ev(EV_WR, 1 + i, i);
    push_ev(EV_RE, 5, 0);
    for (int k = 0; k < iters; k++) push_ev(EV_ITD, 10 + 6 * k, k);
  endtask

  task automatic test_sb_empty(string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d predicted events never seen, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.load_valid = 1'b0;
    bus.relax_update = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.state, bus.busy, bus.done, bus.load_ready, bus.row_wr, bus.read_enable_global,
         bus.iteration_done, bus.converged, bus.neg_cycle, bus.row_addr, bus.iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d busy=%b done=%b iter=%0d, expected all 0",
               bus.state, bus.busy, bus.done, bus.iter_count);
    end
    rst_global_n = 1'b1;
    tick();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d expected 0", bus.state);
    end
  endtask

  task automatic test_full_run();
    begin_run(1, 1);
    push_std_events(MAX_ITER);
    push_ev(EV_DONE, 31, done_exp(0, 1, 4));
    launch();
    run_to(29);
    checks++;
    if (bus.state !== 3'd3 || {bus.converged, bus.neg_cycle} !== 2'b01) begin
      errors++;
      $display("FAIL full_drain_status: state=%0d conv=%b neg=%b, expected 3 0 1",
               bus.state, bus.converged, bus.neg_cycle);
    end
    bus.start = 1'b1;
    run_to(32);
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL full_start_ignored: state=%0d expected 0", bus.state);
    end
    run_to(35);
    test_sb_empty("full");
  endtask

  task automatic test_backpressure();
    begin_run(1, 2);
    for (int i = 0; i < NODES; i++) push_ev(EV_WR, 1 + 2 * i, i);
    push_ev(EV_RE, 8, 0);
    for (int k = 0; k < MAX_ITER; k++) push_ev(EV_ITD, 13 + 6 * k, k);
    push_ev(EV_DONE, 34, done_exp(0, 1, 4));
    launch();
    run_to(7);
    checks++;
    if (bus.state !== 3'd1) begin
      errors++;
      $display("FAIL bp_load: state=%0d expected 1", bus.state);
    end
    run_to(8);
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL bp_run: state=%0d expected 2", bus.state);
    end
    run_to(37);
    test_sb_empty("bp");
  endtask

`ifdef BF_EARLY_EXIT_EN
  task automatic test_early_exit();
    begin_run(2, 1);
    push_std_events(2);
    push_ev(EV_DONE, 19, done_exp(1, 0, 2));
    launch();
    run_to(17);
    checks++;
    if (bus.state !== 3'd3 || {bus.converged, bus.neg_cycle} !== 2'b10) begin
      errors++;
      $display("FAIL early_drain: state=%0d conv=%b neg=%b, expected 3 1 0",
               bus.state, bus.converged, bus.neg_cycle);
    end
    run_to(22);
    test_sb_empty("early");
  endtask
`else
  task automatic test_last_cycle_update();
    begin_run(3, 1);
    push_std_events(MAX_ITER);
    push_ev(EV_DONE, 31, done_exp(0, 1, 4));
    launch();
    run_to(33);
    test_sb_empty("lastcyc");
    begin_run(0, 1);
    push_std_events(MAX_ITER);
    push_ev(EV_DONE, 31, done_exp(1, 0, 4));
    launch();
    run_to(33);
    test_sb_empty("noupd");
  endtask
`endif

  task automatic test_abort();
    begin_run(1, 1);
    push_std_events(2);
    launch();
    run_to(18);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || bus.iter_count !== 11'd2 || bus.busy !== 1'b0 ||
        {bus.converged, bus.neg_cycle} !== 2'b00) begin
      errors++;
      $display("FAIL abort_run: state=%0d iter=%0d busy=%b conv=%b neg=%b, expected 0 2 0 0 0",
               bus.state, bus.iter_count, bus.busy, bus.converged, bus.neg_cycle);
    end
    run_to(34);
    test_sb_empty("abort");
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL abort_wins: state=%0d expected 0", bus.state);
    end
    // Abort after the verdict is latched must wipe it and suppress done.
    begin_run(1, 1);
    push_std_events(MAX_ITER);
    launch();
    run_to(29);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.state !== 3'd0 || bus.neg_cycle !== 1'b0 || bus.iter_count !== 11'd4) begin
      errors++;
      $display("FAIL abort_drain: state=%0d neg=%b iter=%0d, expected 0 0 4",
               bus.state, bus.neg_cycle, bus.iter_count);
    end
    run_to(35);
    test_sb_empty("abort_drain");
  endtask

  task automatic test_reset_mid_run();
    begin_run(1, 1);
    push_std_events(1);
    launch();
    run_to(12);
    rst_global_n = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.busy, bus.done, bus.load_ready, bus.row_wr, bus.read_enable_global,
         bus.iteration_done, bus.converged, bus.neg_cycle, bus.row_addr, bus.iter_count} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: state=%0d busy=%b iter=%0d, expected all 0",
               bus.state, bus.busy, bus.iter_count);
    end
    test_sb_empty("midrst");
    @(posedge clk);
    #1;
    rst_global_n = 1'b1;
    begin_run(1, 1);
    push_std_events(1);
    launch();
    run_to(5);
    checks++;
    if (bus.iter_count !== 11'd0 || bus.read_enable_global !== 1'b1) begin
      errors++;
      $display("FAIL midrst_fresh: iter=%0d re=%b, expected 0 1",
               bus.iter_count, bus.read_enable_global);
    end
    run_to(11);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    run_to(14);
    test_sb_empty("fresh");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
`ifdef BF_EARLY_EXIT_EN
    test_early_exit();
`else
    test_last_cycle_update();
`endif
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_sequencer.md
# bf_sequencer

Top-level run controller for the Bellman-Ford relaxation array. It accepts a start command and loads the NODES-row weight matrix through a valid/ready handshake. It then runs fixed-length relaxation iterations, restarting the step/phase counter chain with `read_enable_global` and pulsing `iteration_done` once per iteration, and stops on the iteration limit or, optionally, on convergence. It reports completion, convergence and negative-cycle status to the host interface.

## Interface
Parameters:
- `NODES`, 32, matrix rows to load; one row per accepted beat.
- `ITER_CYCLES`, 6, clock cycles per relaxation iteration (3 steps x 2 phases); minimum 2.
- `MAX_ITER`, 20, iteration limit; valid range 1 to 2^ITER_W-1.
- `ITER_W`, 11, width of `iter_count`.
- `DRAIN_CYCLES`, 2, datapath flush cycles after the last iteration; minimum 1.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_global_n` input 1: asynchronous, active-low reset.
- `start` input 1: run request; sampled in IDLE only.
- `abort` input 1: synchronous cancel; honoured in any state.
- `load_valid` input 1: weight-row source has a row.
- `relax_update` input 1: datapath changed at least one distance this cycle.
- `load_ready` output 1: high in LOAD.
- `row_wr` output 1: `load_valid & load_ready` (combinational); write strobe to the matrix RAM.
- `row_addr` output clog2(NODES): row index being written.
- `read_enable_global` output 1: counter-chain restart pulse.
- `iteration_done` output 1: one-cycle end-of-iteration pulse.
- `iter_count` output ITER_W: completed iterations.
- `busy` output 1: high in LOAD, RUN, DRAIN.
- `done` output 1: one-cycle completion pulse.
- `converged` output 1: sticky status; valid from `done` until next start.
- `neg_cycle` output 1: sticky status; valid from `done` until next start.
- `state` output 3: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.

## Operation
- Reset (asynchronous on `rst_global_n`=0):
  - State goes to IDLE.
  - All counters and all outputs are 0.
- IDLE, with `start`=1 and `abort`=0:
  - Next state is LOAD.
  - `row_addr`, `iter_count`, `converged` and `neg_cycle` clear.
- LOAD:
  - Each accepted beat increments `row_addr`.
  - The beat accepted at `row_addr`=NODES-1 moves to RUN; `row_addr` wraps to 0.
  - `load_valid` gaps stall LOAD indefinitely.
- RUN:
  - Internal cycle counter `cyc` runs 0..ITER_CYCLES-1.
  - `read_enable_global`=1 only when `cyc`=0 and `iter_count`=0, i.e. once per run.
  - `iteration_done`=1 when `cyc`=ITER_CYCLES-1.
  - Sticky flag `upd` ORs `relax_update` over every RUN cycle of the iteration. The end-of-iteration decision uses `upd | relax_update` of the last cycle; call this U.
- End of iteration (at the edge after `iteration_done`):
  - `iter_count` increments; `cyc` goes to 0 and `upd` clears.
  - If the new count equals MAX_ITER: `neg_cycle`=U, `converged`=!U, go to DRAIN.
  - Else, with early exit compiled in and U=0: `converged`=1, go to DRAIN.
  - Else: stay in RUN.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles; `relax_update` is ignored.
  - Then goes to DONE.
- DONE:
  - Lasts exactly 1 cycle with `done`=1 and `busy`=0, then returns to IDLE.
  - `start` in DONE is ignored.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE with no `done` pulse.
  - `converged` and `neg_cycle` clear; `iter_count` holds.
  - `abort` together with `start` in IDLE: `abort` wins and the block stays in IDLE.
- `start` outside IDLE is ignored. No request is queued.

## Timing
- Everything except `row_wr` is a registered output or decoded from state and counter registers; there are no combinational paths from inputs.
- Start edge at t0: LOAD begins in cycle t0+1.
- With `load_valid` held high, the first RUN cycle (`read_enable_global`=1) is t0+1+NODES.
- Full run with no early exit: `done` is high in cycle t0 + 1 + NODES + MAX_ITER×ITER_CYCLES + DRAIN_CYCLES.
- `iteration_done` pulses are exactly ITER_CYCLES apart.
- `iter_count` updates the cycle after each pulse.
- `converged` and `neg_cycle` are set on entry to DRAIN and hold until the next accepted start or an abort.

## Configuration
- `BF_EARLY_EXIT_EN` defined:
  - An iteration with U=0 ends the run after that iteration.
  - `converged`=1, `neg_cycle`=0.
- `BF_EARLY_EXIT_EN` undefined:
  - Always runs MAX_ITER iterations.
  - Status is decided only from U of the final iteration.
  - Port list is identical in both builds.

## Test plan
Bench parameters: NODES=4, ITER_CYCLES=6, MAX_ITER=4, DRAIN_CYCLES=2 unless stated.
- Reset and status:
  - Assert `rst_global_n`=0 mid-RUN -> outputs 0 and `state`=0 immediately.
  - Start after release -> fresh run with `iter_count`=0.
- Full run, feature off:
  - Stimulus: `start` at t0, `load_valid`=1, `relax_update`=1 every cycle.
  - Required: `row_wr` for `row_addr` 0..3 in t0+1..t0+4.
  - Required: `read_enable_global` at t0+5 only.
  - Required: `iteration_done` at t0+10, t0+16, t0+22 and t0+28.
  - Required: `done` at t0+31 with `neg_cycle`=1, `converged`=0, `iter_count`=4.
- Early exit, `BF_EARLY_EXIT_EN` defined:
  - Stimulus: `relax_update` high only during iteration 0.
  - Required: exit after iteration 1 and `done` at t0+19 with `converged`=1, `neg_cycle`=0, `iter_count`=2.
- Load backpressure:
  - Stimulus: `load_valid` toggling 1,0,1,0...
  - Required: exactly 4 `row_wr` pulses with `row_addr` 0,1,2,3, and RUN entered the cycle after the 4th beat.
- Abort and ignored start:
  - Stimulus: `abort` during RUN with `iter_count`=2.
  - Required: IDLE next cycle, no `done`, `iter_count` stays 2.
  - Stimulus: `start` during DRAIN -> ignored, single `done`.
- Last-cycle update, feature off:
  - Stimulus: `relax_update` pulses only on the final cycle of iteration 3.
  - Required: `neg_cycle`=1 at `done`.
